// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } if_state_e;

   localparam logic [31:0] NOP_INST      = 32'h0000_0000;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage feeding the IF/ID register
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] fetch_pc_o,
   output logic [31:0] fetch_inst_o,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_count_o
);

   if_state_e   state;
   logic [31:0] pc_q;
   logic [31:0] hold_q;
   logic [31:0] count_q;
   logic [31:0] tgt_q;
   logic [31:0] pc_next_seq;
   logic [31:0] redirect_tgt;
   logic        accept;

   assign pc_next_seq  = pc_q + 32'(PC_STEP);
   assign redirect_tgt = align_pc(redirect_pc_i);

   assign imem_addr_o   = pc_q;
   assign fetch_pc_o    = pc_q;
   assign fetch_count_o = count_q;
   assign accept        = fetch_valid_o && !stall_i && !redirect_i;

   // Data path is combinational so a zero-wait ack is presented in the request cycle.
   always_comb begin
      imem_req_o    = 1'b0;
      fetch_valid_o = 1'b0;
      fetch_inst_o  = NOP_INST;
      case (state)
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ack_i && !redirect_i) begin
               fetch_valid_o = 1'b1;
               fetch_inst_o  = imem_rdata_i;
            end
         end
         S_HOLD: begin
            fetch_valid_o = 1'b1;
            fetch_inst_o  = hold_q;
         end
         S_DRAIN: imem_req_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INST;
         count_q <= 32'd0;
         tgt_q   <= RESET_PC;
      end else begin
         if (accept) begin
            pc_q    <= pc_next_seq;
            count_q <= count_q + 32'd1;
         end
         case (state)
            S_IDLE: begin
               state <= S_FETCH;
               if (redirect_i) pc_q <= redirect_tgt;
            end
            S_FETCH: begin
               if (imem_ack_i) begin
                  if (redirect_i) begin
                     pc_q <= redirect_tgt;
                  end else if (stall_i) begin
                     hold_q <= imem_rdata_i;
                     state  <= S_HOLD;
                  end
               end else if (redirect_i) begin
                  // The bus transaction cannot be withdrawn; finish it and refetch later.
                  tgt_q <= redirect_tgt;
                  state <= S_DRAIN;
               end
            end
            S_HOLD: begin
               if (redirect_i) begin
                  pc_q  <= redirect_tgt;
                  state <= S_FETCH;
               end else if (!stall_i) begin
                  state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (imem_ack_i) begin
                  pc_q  <= redirect_i ? redirect_tgt : tgt_q;
                  state <= S_FETCH;
               end else if (redirect_i) begin
                  tgt_q <= redirect_tgt;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic [31:0] fetch_pc_o;
   logic [31:0] fetch_inst_o;
   logic        fetch_valid_o;
   logic [31:0] fetch_count_o;

   int checks = 0;
   int errors = 0;

   if_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .fetch_pc_o    (fetch_pc_o),
      .fetch_inst_o  (fetch_inst_o),
      .fetch_valid_o (fetch_valid_o),
      .fetch_count_o (fetch_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic [31:0] rdata);
      @(negedge clk_i);
      imem_ack_i    = ack;
      stall_i       = stall;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      imem_rdata_i  = rdata;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] inst);
      check_eq({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, req});
      check_eq({tag, ".addr"},  imem_addr_o, addr);
      check_eq({tag, ".pc"},    fetch_pc_o, addr);
      check_eq({tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, valid});
      check_eq({tag, ".inst"},  fetch_inst_o, inst);
   endtask

   initial begin
      // reset state
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_out("rst", 1'b0, 32'h0, 1'b0, 32'h0);
      check_eq("rst.count", fetch_count_o, 32'd0);

      // zero-wait stream: idle cycle, then addrs 0,4,8,12
      @(negedge clk_i);
      rst_i = 1'b0;
      imem_ack_i = 1'b1;
      imem_rdata_i = 32'hA000_0000;
      #1;
      expect_out("idle", 1'b0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA000_0001);
      expect_out("zw0", 1'b1, 32'h0, 1'b1, 32'hA000_0001);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA000_0002);
      expect_out("zw1", 1'b1, 32'h4, 1'b1, 32'hA000_0002);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA000_0003);
      expect_out("zw2", 1'b1, 32'h8, 1'b1, 32'hA000_0003);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA000_0004);
      expect_out("zw3", 1'b1, 32'hC, 1'b1, 32'hA000_0004);

      // ack under stall -> hold buffer for 3 cycles, release on third
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h2002_0005);
      check_eq("zw.count", fetch_count_o, 32'd4);
      expect_out("stall.ack", 1'b1, 32'h10, 1'b1, 32'h2002_0005);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
      expect_out("hold0", 1'b0, 32'h10, 1'b1, 32'h2002_0005);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
      expect_out("hold1", 1'b0, 32'h10, 1'b1, 32'h2002_0005);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      expect_out("hold2", 1'b0, 32'h10, 1'b1, 32'h2002_0005);
      check_eq("hold2.count", fetch_count_o, 32'd4);

      // redirect while waiting on ack -> drain at old addr, then refetch at 0x40
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0043, 32'h0);
      check_eq("rel.count", fetch_count_o, 32'd5);
      expect_out("rd.req", 1'b1, 32'h14, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_out("drain0", 1'b1, 32'h14, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_out("drain1", 1'b1, 32'h14, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_0001);
      expect_out("drain.ack", 1'b1, 32'h14, 1'b0, 32'h0);

      // redirect in HOLD with stall -> buffer dropped, count unchanged
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_2222);
      expect_out("tgt40", 1'b1, 32'h40, 1'b1, 32'h1111_2222);
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0);
      expect_out("hold.rd", 1'b0, 32'h40, 1'b1, 32'h1111_2222);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_out("post.hold.rd", 1'b1, 32'h100, 1'b0, 32'h0);
      check_eq("hold.rd.count", fetch_count_o, 32'd5);

      // ack with redirect -> data dropped, stay fetching at new target; then wrap
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hBAD0_0002);
      expect_out("ack.rd", 1'b1, 32'h100, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h3333_4444);
      expect_out("wrap.top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h3333_4444);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h5555_6666);
      expect_out("wrap.zero", 1'b1, 32'h0, 1'b1, 32'h5555_6666);
      check_eq("wrap.count", fetch_count_o, 32'd6);

      // latest redirect during drain wins
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
      check_eq("pre.drain.count", fetch_count_o, 32'd7);
      expect_out("d2.req", 1'b1, 32'h4, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0302, 32'h0);
      expect_out("d2.over", 1'b1, 32'h4, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_0003);
      expect_out("d2.ack", 1'b1, 32'h4, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
      expect_out("d2.tgt", 1'b1, 32'h300, 1'b0, 32'h0);

      // asynchronous reset mid-drain, off the clock edge
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_out("d3", 1'b1, 32'h300, 1'b0, 32'h0);
      #2 rst_i = 1'b1;
      #1;
      expect_out("arst", 1'b0, 32'h0, 1'b0, 32'h0);
      check_eq("arst.count", fetch_count_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      imem_ack_i = 1'b1;
      imem_rdata_i = 32'h7777_0000;
      #1;
      expect_out("arst.idle", 1'b0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h7777_0001);
      expect_out("resume0", 1'b1, 32'h0, 1'b1, 32'h7777_0001);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h7777_0002);
      expect_out("resume1", 1'b1, 32'h4, 1'b1, 32'h7777_0002);
      check_eq("resume.count", fetch_count_o, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
